// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - opcode and instruction field definitions shared by cpu_sequencer and control_unit
// Instruction word: [15:12] opcode, [11:9] dest, [8:6] src1, [5:3] src2, [2:0] unused.
package cpu_defs_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_CMP  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DEST_MSB = 11;
  localparam int DEST_LSB = 9;
  localparam int SRC1_MSB = 8;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_MSB = 5;
  localparam int SRC2_LSB = 3;
  localparam int TGT_W    = 12;  // JMP target occupies [11:0]

  function automatic logic [3:0] get_opcode(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle fetch/decode/execute/writeback controller for the mini CPU
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   run                level, start/continue execution
//   imem_req/addr      fetch request (held until ack) and address (= pc)
//   imem_ack/rdata     fetch accept and instruction word
//   instr              instruction register, feeds control_unit
//   cu_write_en        control_unit write enable for the current instruction
//   alu_en, rf_we      single-cycle ALU capture and register-file write strobes
//   pc                 program counter
//   busy, halted, fault  status: executing, HALT executed, fetch timeout
module cpu_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  input  logic            cu_write_en,
  output logic            alu_en,
  output logic            rf_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            fault
);
  import cpu_defs_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // The counter holds the number of no-ack cycles already spent in FETCH, so
  // the TIMEOUT-th consecutive no-ack cycle is the one seeing TO_LAST.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [15:0]     ir;
  logic [7:0]      fetch_cnt;
  logic [PC_W-1:0] jmp_target;
  logic            is_jmp;
  logic            fetch_timeout;

  assign instr         = ir;
  assign is_jmp        = (get_opcode(ir) == OP_JMP);
  // An ack in the timeout cycle still wins.
  assign fetch_timeout = (state == S_FETCH) && !imem_ack && (fetch_cnt == TO_LAST);
  assign imem_addr     = imem_req ? pc : '0;

  // Truncate or zero-extend the 12-bit target field to PC_W.
  always_comb begin
    jmp_target = '0;
    for (int i = 0; i < PC_W && i < TGT_W; i++) jmp_target[i] = ir[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      fetch_cnt <= '0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Non-FETCH states hold the counter at zero, so it starts clean on entry.
      fetch_cnt <= (state == S_FETCH && !imem_ack) ? fetch_cnt + 8'd1 : 8'd0;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (fetch_timeout) fault <= 1'b1;
      if (state == S_DECODE && get_opcode(ir) == OP_HALT) halted <= 1'b1;
      if (state == S_WB) pc <= is_jmp ? jmp_target : pc + PC_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack)           state_nxt = S_DECODE;
        else if (fetch_timeout) state_nxt = S_HALT;
      end
      S_DECODE: begin
        busy      = 1'b1;
        state_nxt = (get_opcode(ir) == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        alu_en    = !is_jmp;
        state_nxt = S_WB;
      end
      S_WB: begin
        busy      = 1'b1;
        rf_we     = cu_write_en && !is_jmp;
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    // A reset cycle must not launch a fetch or a write.
    if (rst) begin
      imem_req = 1'b0;
      alu_en   = 1'b0;
      rf_we    = 1'b0;
    end
  end

endmodule
